alu_operand_sync_ctrl: RTL and testbench

- Central sequencer for the operand ports of one ALU. Arbitrates which port may load the P-Config block; the other ports see is_Configured and bypass.
- After configuration, waits until every enabled operand port reports ready, then fires the datapath only when all enabled ports present valid data in the same cycle. Ports whose data arrives early get a nack.
- Counts fired words, then waits for the execution pipeline to drain before releasing the ALU.

---
 rtl/alu_operand_sync_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_operand_sync_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sync_ctrl.sv
// Operand-port sequencer for one ALU: config grant, ready/valid sync, drain.
// Define ALU_SYNC_RR_ARB_EN for round-robin config arbitration.
module alu_operand_sync_ctrl #(
   parameter int NUM_PORTS    = 3,
   parameter int WIDTH_LENGTH = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_PORTS-1:0]    I_Port_En,
   input  logic [NUM_PORTS-1:0]    I_Req_Config,
   input  logic [NUM_PORTS-1:0]    I_Config_End,
   input  logic [NUM_PORTS-1:0]    I_Ready,
   input  logic [NUM_PORTS-1:0]    I_Valid,
   input  logic [NUM_PORTS-1:0]    I_Rls,
   input  logic [WIDTH_LENGTH-1:0] I_Length,
   input  logic                    I_Exec_Done,
   output logic [NUM_PORTS-1:0]    O_Grant_Config,
   output logic                    O_Configured,
   output logic                    O_Fire,
   output logic [NUM_PORTS-1:0]    O_Nack,
   output logic                    O_Busy,
   output logic                    O_Done,
   output logic                    O_Error
);

   typedef enum logic [2:0] {
      IDLE,
      CONFIG,
      WAIT_READY,
      STREAM,
      DRAIN,
      FINISH
   } state_t;

   localparam logic [WIDTH_LENGTH-1:0] ONE = WIDTH_LENGTH'(1);

   state_t                  state;
   logic [WIDTH_LENGTH-1:0] count;
   logic [NUM_PORTS-1:0]    req;
   logic [NUM_PORTS-1:0]    pick;
   logic                    found;
   logic                    en_ready;
   logic                    rls_all;
   logic                    all_valid;
   logic                    cfg_end;

   assign req       = I_Req_Config & I_Port_En;
   assign en_ready  = ((I_Ready & I_Port_En) == I_Port_En);
   assign rls_all   = ((I_Rls & I_Port_En) == I_Port_En);
   assign all_valid = &(I_Valid | ~I_Port_En);
   assign cfg_end   = |(I_Config_End & O_Grant_Config);
   assign O_Busy    = (state != IDLE);

`ifdef ALU_SYNC_RR_ARB_EN
   localparam int PW = $clog2(NUM_PORTS);

   logic [PW-1:0] ptr;
   logic [PW-1:0] pick_idx;

   // Search begins one past the last granted port.
   always_comb begin
      int idx;
      pick     = '0;
      pick_idx = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_PORTS)
            idx = idx - NUM_PORTS;
         if (!found && req[idx]) begin
            found     = 1'b1;
            pick[idx] = 1'b1;
            pick_idx  = PW'(idx);
         end
      end
   end
`else
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            pick[i] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      O_Fire = 1'b0;
      O_Nack = '0;
      case (state)
         WAIT_READY: begin
            if (!en_ready)
               O_Nack = I_Valid & I_Port_En;
         end
         STREAM: begin
            O_Fire = all_valid;
            O_Nack = I_Valid & I_Port_En
                   & {NUM_PORTS{~all_valid}};
         end
         DRAIN: begin
            O_Nack = I_Valid & I_Port_En;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         count          <= '0;
         O_Grant_Config <= '0;
         O_Configured   <= 1'b0;
         O_Done         <= 1'b0;
         O_Error        <= 1'b0;
`ifdef ALU_SYNC_RR_ARB_EN
         ptr            <= '0;
`endif
      end else begin
         O_Done  <= 1'b0;
         O_Error <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  O_Grant_Config <= pick;
                  state          <= CONFIG;
`ifdef ALU_SYNC_RR_ARB_EN
                  ptr            <= pick_idx;
`endif
               end else if (O_Configured) begin
                  state <= WAIT_READY;
               end
            end
            CONFIG: begin
               if (cfg_end) begin
                  O_Configured   <= 1'b1;
                  O_Grant_Config <= '0;
                  state          <= WAIT_READY;
               end
            end
            WAIT_READY: begin
               // Empty mask aborts; config dropped to avoid re-entry loop.
               if (I_Port_En == '0) begin
                  O_Error      <= 1'b1;
                  O_Configured <= 1'b0;
                  state        <= IDLE;
               end else if (en_ready) begin
                  count <= I_Length;
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (all_valid) begin
                  if (count == '0 || rls_all)
                     state <= DRAIN;
                  else
                     count <= count - ONE;
               end
            end
            DRAIN: begin
               if (I_Exec_Done) begin
                  O_Done <= 1'b1;
                  state  <= FINISH;
               end
            end
            FINISH: begin
               O_Configured <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_sync_ctrl.sv
// Directed bench for alu_operand_sync_ctrl (NUM_PORTS=3).
// Honours ALU_SYNC_RR_ARB_EN for the second-grant expectation.
module tb_alu_operand_sync_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] en    = '0;
   logic [2:0] req   = '0;
   logic [2:0] cend  = '0;
   logic [2:0] rdy   = '0;
   logic [2:0] vld   = '0;
   logic [2:0] rls   = '0;
   logic [9:0] len   = '0;
   logic       xdone = 1'b0;

   logic [2:0] grant;
   logic       configured;
   logic       fire;
   logic [2:0] nack;
   logic       busy;
   logic       done;
   logic       error;

   int n_pass = 0;
   int n_total = 0;

`ifdef ALU_SYNC_RR_ARB_EN
   localparam logic [2:0] GRANT2 = 3'b100;
`else
   localparam logic [2:0] GRANT2 = 3'b010;
`endif

   alu_operand_sync_ctrl #(
      .NUM_PORTS   (3),
      .WIDTH_LENGTH(10)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .I_Port_En     (en),
      .I_Req_Config  (req),
      .I_Config_End  (cend),
      .I_Ready       (rdy),
      .I_Valid       (vld),
      .I_Rls         (rls),
      .I_Length      (len),
      .I_Exec_Done   (xdone),
      .O_Grant_Config(grant),
      .O_Configured  (configured),
      .O_Fire        (fire),
      .O_Nack        (nack),
      .O_Busy        (busy),
      .O_Done        (done),
      .O_Error       (error)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      settle();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_cfg", 32'(configured), 32'h0);
      check("rst_fire", 32'(fire), 32'h0);
      check("rst_nack", 32'(nack), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(error), 32'h0);

      // Operation 1: arbitration, skewed stream of four words
      en  = 3'b111;
      req = 3'b110;
      settle();
      check("grant_lat", 32'(grant), 32'h0);
      tick();
      check("grant1", 32'(grant), 32'h2);
      check("busy_cfg", 32'(busy), 32'h1);
      req = 3'b001;
      tick();
      check("grant_hold", 32'(grant), 32'h2);
      req  = 3'b000;
      cend = 3'b001;
      tick();
      check("cend_other", 32'(configured), 32'h0);
      check("grant_hold2", 32'(grant), 32'h2);
      cend = 3'b010;
      tick();
      cend = 3'b000;
      check("cfg_set", 32'(configured), 32'h1);
      check("grant_drop", 32'(grant), 32'h0);
      rdy = 3'b011;
      vld = 3'b001;
      settle();
      check("wr_nack", 32'(nack), 32'h1);
      check("wr_fire", 32'(fire), 32'h0);
      tick();
      rdy = 3'b111;
      vld = 3'b000;
      len = 10'd3;
      tick();
      vld = 3'b001;
      settle();
      check("skew1_fire", 32'(fire), 32'h0);
      check("skew1_nack", 32'(nack), 32'h1);
      tick();
      vld = 3'b011;
      settle();
      check("skew2_fire", 32'(fire), 32'h0);
      check("skew2_nack", 32'(nack), 32'h3);
      tick();
      vld   = 3'b111;
      xdone = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("st_fire", 32'(fire), 32'h1);
         check("st_nack", 32'(nack), 32'h0);
         tick();
      end
      xdone = 1'b0;
      settle();
      check("dr_fire", 32'(fire), 32'h0);
      check("dr_nack", 32'(nack), 32'h7);
      check("dr_done", 32'(done), 32'h0);
      check("dr_busy", 32'(busy), 32'h1);
      vld = 3'b000;
      tick();
      check("dr_wait", 32'(done), 32'h0);
      xdone = 1'b1;
      tick();
      xdone = 1'b0;
      check("done1", 32'(done), 32'h1);
      tick();
      check("done1_w", 32'(done), 32'h0);
      check("cfg_clr1", 32'(configured), 32'h0);
      check("idle1", 32'(busy), 32'h0);

      // Operation 2: release token ends the block early
      req = 3'b110;
      tick();
      req = 3'b000;
      check("grant2", 32'(grant), 32'(GRANT2));
      cend = GRANT2;
      tick();
      cend = 3'b000;
      check("cfg2", 32'(configured), 32'h1);
      len = 10'd5;
      tick();
      vld = 3'b111;
      rls = 3'b111;
      settle();
      check("rls_fire", 32'(fire), 32'h1);
      tick();
      vld = 3'b000;
      rls = 3'b000;
      vld = 3'b111;
      settle();
      check("rls_drain", 32'(fire), 32'h0);
      vld = 3'b000;
      tick();
      xdone = 1'b1;
      tick();
      xdone = 1'b0;
      check("done2", 32'(done), 32'h1);
      tick();
      check("done2_w", 32'(done), 32'h0);
      check("cfg_clr2", 32'(configured), 32'h0);
      check("idle2", 32'(busy), 32'h0);

      // Empty enable mask at stream start
      req = 3'b001;
      tick();
      req = 3'b000;
      check("grant3", 32'(grant), 32'h1);
      cend = 3'b001;
      tick();
      cend = 3'b000;
      en   = 3'b000;
      vld  = 3'b111;
      settle();
      check("err_fire", 32'(fire), 32'h0);
      check("err_nack", 32'(nack), 32'h0);
      tick();
      check("err_pulse", 32'(error), 32'h1);
      check("err_idle", 32'(busy), 32'h0);
      tick();
      check("err_w", 32'(error), 32'h0);
      check("err_fire2", 32'(fire), 32'h0);
      vld = 3'b000;

      // Reset while streaming with count 2
      en  = 3'b111;
      req = 3'b100;
      tick();
      req = 3'b000;
      check("grant4", 32'(grant), 32'h4);
      cend = 3'b100;
      tick();
      cend = 3'b000;
      len  = 10'd2;
      tick();
      vld = 3'b111;
      settle();
      check("pre_rst_fire", 32'(fire), 32'h1);
      reset = 1'b1;
      tick();
      check("mr_fire", 32'(fire), 32'h0);
      check("mr_cfg", 32'(configured), 32'h0);
      check("mr_busy", 32'(busy), 32'h0);
      check("mr_nack", 32'(nack), 32'h0);
      reset = 1'b0;
      vld   = 3'b000;
      tick();
      check("mr_done", 32'(done), 32'h0);
      check("mr_busy2", 32'(busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
